// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - pipelined immediate extension unit; optional prefix fusion under IMM_EXT_PREFIX_EN
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_fused
);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_fused_q, out_fused_d;
    logic             accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Plain (non-fused) extension; mode 11 falls through to zero-on-high.
    function automatic logic [OUT_W-1:0] extend(input logic [1:0] mode, input logic [IN_W-1:0] imm);
        logic [OUT_W-1:0] r;
        r = '0;
        case (mode)
            2'b00: begin
                r = {OUT_W{imm[IN_W-1]}};
                r[IN_W-1:0] = imm;
            end
            2'b01: r[OUT_W-1:OUT_W-IN_W] = imm;
            default: r[IN_W-1:0] = imm;
        endcase
        return r;
    endfunction

`ifdef IMM_EXT_PREFIX_EN
    typedef enum logic {
        NOPFX = 1'b0,
        PFX   = 1'b1
    } pfx_state_e;

    pfx_state_e      state_q, state_d;
    logic [IN_W-1:0] prefix_q, prefix_d;

    // Prefix high half above the current low half, zero above 2*IN_W.
    function automatic logic [OUT_W-1:0] fuse(input logic [IN_W-1:0] hi, input logic [IN_W-1:0] lo);
        logic [OUT_W-1:0] r;
        r = '0;
        r[2*IN_W-1:IN_W] = hi;
        r[IN_W-1:0]      = lo;
        return r;
    endfunction

    // Next state: flush wins over accept; a mode-11 accept only updates the prefix.
    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_fused_d = out_fused_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = NOPFX;
            prefix_d    = '0;
        end else if (accept) begin
            if (in_mode == 2'b11) begin
                state_d  = PFX;
                prefix_d = in_imm;
            end else begin
                state_d     = NOPFX;
                out_valid_d = 1'b1;
                if (state_q == PFX && in_mode != 2'b01) begin
                    out_data_d  = fuse(prefix_q, in_imm);
                    out_fused_d = 1'b1;
                end else begin
                    out_data_d  = extend(in_mode, in_imm);
                    out_fused_d = 1'b0;
                end
            end
        end
    end

    // State, prefix and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= NOPFX;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_fused_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_fused_q <= out_fused_d;
        end
    end

    assign out_fused = out_fused_q;
`else
    // Next output: flush drops the held result; every accept produces a result.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_fused_d = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = extend(in_mode, in_imm);
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_fused_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_fused_q <= out_fused_d;
        end
    end

    assign out_fused = 1'b0;
`endif

endmodule
